// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and sequencer for a shared 4-to-1, 2-bit mux channel.
// Four requesters (A..D) compete for the channel. One requester at a time
// holds a tenure, and a tenure lasts at most MAX_HOLD cycles. The arbiter
// drives the mux select {S1,S0} and registers the selected pair onto a
// valid-qualified output.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per tenure (1..15)
//   CNT_W     hold-counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req[3:0]   in   request lines, bit0=A .. bit3=D
//   data_in    in   packed pairs A=[1:0] B=[3:2] C=[5:4] D=[7:6]
//   gnt[3:0]   out  registered one-hot grant, zero outside a tenure
//   sel[1:0]   out  registered mux select, 00=A .. 11=D
//   out_data   out  registered selected pair, lags sel by one cycle
//   out_valid  out  out_data carries granted data (lags gnt by one cycle)
//   busy       out  registered, high while in GRANT or GAP
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [7:0] data_in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic [1:0] out_data,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Last hold-counter value of a tenure; the counter never passes it.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [1:0]       out_data_q;
    logic             out_valid_q;

    logic [1:0]       pick_idx_s;
    logic             pick_found_s;
    logic [1:0]       scan_idx_s;

    // Priority scan: the first requesting index starting at ptr and wrapping mod 4.
    always_comb begin
        pick_idx_s   = 2'd0;
        pick_found_s = 1'b0;
        scan_idx_s   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx_s = ptr_q + 2'(k);
            if (!pick_found_s && req[scan_idx_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = scan_idx_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state logic for the tenure FSM, pointer, hold counter, grant and select.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    gnt_d   = 4'b0001 << pick_idx_s;
                    sel_d   = pick_idx_s;
                    hold_d  = {CNT_W{1'b0}};
                    state_d = ST_GRANT;
                end else begin
                    gnt_d   = 4'b0000;
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // sel_q names the current owner for the whole tenure.
                // Release on a dropped request or when the tenure has run MAX_HOLD cycles.
                if (!req[sel_q] || (hold_q == HOLD_LAST)) begin
                    gnt_d   = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                    state_d = ST_GAP;
                end else begin
                    hold_d  = hold_q + HOLD_ONE;
                    state_d = ST_GRANT;
                end
            end
            ST_GAP: begin
                gnt_d   = 4'b0000;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = 4'b0000;
                hold_d  = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_GRANT) || (state_d == ST_GAP);
    end

    // State, pointer, counter and grant/select registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            hold_q  <= {CNT_W{1'b0}};
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    // Output stage: register the pair addressed by the current select, one cycle behind gnt/sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= 2'b00;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= data_in[{sel_q, 1'b0} +: 2];
            out_valid_q <= |gnt_q;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Scoreboard bench for mux4_rr_arbiter. Two instances (MAX_HOLD=8 and
// MAX_HOLD=2) share the same stimulus. A tenure-level reference model
// predicts each instance's outputs for every clock. The stimulus process
// pushes these predictions into per-instance queues. A separate monitor pops
// the queues and compares the predictions with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [1:0] data;
        logic       valid;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [7:0] data_in = 8'h00;

    logic [3:0] gnt0, gnt1;
    logic [1:0] sel0, sel1, od0, od1;
    logic       ov0, ov1, busy0, busy1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference-model state per instance: owner (-1 = none), cycles held,
    // pending gap cycles, priority pointer and last granted index.
    int m_owner[2];
    int m_held [2];
    int m_cool [2];
    int m_ptr  [2];
    int m_sel  [2];

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt0), .sel(sel0), .out_data(od0), .out_valid(ov0), .busy(busy0)
    );

    mux4_rr_arbiter #(.MAX_HOLD(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt1), .sel(sel1), .out_data(od1), .out_valid(ov1), .busy(busy1)
    );

    function automatic int hold_of(input int k);
        return (k == 0) ? 8 : 2;
    endfunction

    // Predict the outputs after the coming clock edge for the given inputs.
    task automatic model_step(input logic r, input logic [3:0] rq, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            if (r) begin
                m_owner[k] = -1; m_held[k] = 0; m_cool[k] = 0;
                m_ptr[k] = 0; m_sel[k] = 0;
                e = '0;
            end else begin
                // The output stage sees the grant and select from before this edge.
                e.valid = (m_owner[k] >= 0);
                e.data  = d[2*m_sel[k] +: 2];
                if (m_owner[k] >= 0) begin
                    m_held[k] = m_held[k] + 1;
                    if (!rq[m_owner[k]] || m_held[k] >= hold_of(k)) begin
                        m_ptr[k]   = (m_owner[k] + 1) % 4;
                        m_owner[k] = -1;
                        m_cool[k]  = 1;
                    end
                end else if (m_cool[k] > 0) begin
                    m_cool[k] = 0;
                end else if (rq != 4'b0000) begin
                    int found = 0;
                    for (int j = 0; j < 4; j++) begin
                        int idx = (m_ptr[k] + j) % 4;
                        if (found == 0 && rq[idx]) begin
                            found      = 1;
                            m_owner[k] = idx;
                            m_sel[k]   = idx;
                            m_held[k]  = 0;
                        end
                    end
                end
                e.gnt  = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
                e.sel  = 2'(m_sel[k]);
                e.busy = (m_owner[k] >= 0) || (m_cool[k] > 0);
            end
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Apply one cycle of stimulus on the falling edge and record the prediction.
    task automatic drive(input logic r, input logic [3:0] rq, input logic [7:0] d);
        @(negedge clk);
        rst     = r;
        req     = rq;
        data_in = d;
        model_step(r, rq, d);
    endtask

    task automatic check_inst(input int k, input exp_t e, input exp_t a);
        checks = checks + 5;
        if (a.gnt !== e.gnt) begin
            errors++;
            $display("FAIL gnt inst%0d cyc%0d got %b expected %b", k, cyc, a.gnt, e.gnt);
        end
        if (a.sel !== e.sel) begin
            errors++;
            $display("FAIL sel inst%0d cyc%0d got %b expected %b", k, cyc, a.sel, e.sel);
        end
        if (a.valid !== e.valid) begin
            errors++;
            $display("FAIL out_valid inst%0d cyc%0d got %b expected %b", k, cyc, a.valid, e.valid);
        end
        if (e.valid && (a.data !== e.data)) begin
            errors++;
            $display("FAIL out_data inst%0d cyc%0d got %b expected %b", k, cyc, a.data, e.data);
        end
        if (a.busy !== e.busy) begin
            errors++;
            $display("FAIL busy inst%0d cyc%0d got %b expected %b", k, cyc, a.busy, e.busy);
        end
    endtask

    // Monitor: one edge after each push, pop the prediction and compare it with the DUT.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0) begin
                exp_t a;
                exp_t e;
                e = q0.pop_front();
                a.gnt = gnt0; a.sel = sel0; a.data = od0; a.valid = ov0; a.busy = busy0;
                check_inst(0, e, a);
            end
            if (q1.size() > 0) begin
                exp_t a;
                exp_t e;
                e = q1.pop_front();
                a.gnt = gnt1; a.sel = sel1; a.data = od1; a.valid = ov1; a.busy = busy1;
                check_inst(1, e, a);
            end
        end
    end

    initial begin
        logic [3:0] rq;
        logic [7:0] d;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_held[k] = 0; m_cool[k] = 0; m_ptr[k] = 0; m_sel[k] = 0;
        end

        // Reset
        repeat (3) drive(1'b1, 4'b0000, 8'h00);
        // Single requester C with data C=10, including re-grants after the forced release.
        repeat (26) drive(1'b0, 4'b0100, 8'b00_10_00_00);
        repeat (3) drive(1'b0, 4'b0000, 8'h00);
        // All requesting: round robin and data steering.
        repeat (40) drive(1'b0, 4'b1111, 8'b11_10_01_00);
        // Early release of A on its 3rd grant cycle, then A and D request.
        repeat (4) drive(1'b0, 4'b0000, 8'h00);
        drive(1'b1, 4'b0000, 8'h00);
        repeat (3) drive(1'b0, 4'b0001, 8'b11_10_01_00);
        drive(1'b0, 4'b0000, 8'b11_10_01_00);
        repeat (8) drive(1'b0, 4'b1001, 8'b11_10_01_00);
        // Pointer wrap: D granted and released, then A and B request.
        repeat (3) drive(1'b0, 4'b0000, 8'h00);
        repeat (3) drive(1'b0, 4'b1000, 8'b01_00_00_00);
        repeat (8) drive(1'b0, 4'b0011, 8'b00_00_10_01);
        // Reset in the middle of a B tenure, then all request.
        repeat (3) drive(1'b0, 4'b0010, 8'b00_00_11_00);
        drive(1'b1, 4'b0010, 8'b00_00_11_00);
        repeat (6) drive(1'b0, 4'b1111, 8'b11_10_01_00);

        // Random traffic with occasional request drops and resets.
        rq = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            d = 8'($urandom);
            drive(($urandom_range(0, 79) == 0), rq, d);
        end

        // Let the monitor drain both queues.
        drive(1'b0, 4'b0000, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ((q0.size() != 0) || (q1.size() != 0)) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4-to-1, 2-bit multiplexer datapath. It shares one 2-bit output channel between four requesters (A, B, C, D) and grants the channel to one requester at a time, for a bounded number of cycles. It drives the mux select pair {S1,S0} and registers the selected 2-bit data onto a valid-qualified output. It sits between the requesting blocks and the downstream consumer of the shared channel.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per tenure; legal range 1..15.
- `CNT_W`, default 4: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  4  request lines: bit0=A, bit1=B, bit2=C, bit3=D.
- `data_in`  in  8  packed pairs: A=[1:0], B=[3:2], C=[5:4], D=[7:6] (bit1 of each pair = X1, bit0 = X0).
- `gnt`  out  4  one-hot grant, registered; all zero when no tenure is active.
- `sel`  out  2  mux select {S1,S0}: 00=A, 01=B, 10=C, 11=D.
- `out_data`  out  2  registered selected pair {Out1,Out0}.
- `out_valid`  out  1  `out_data` carries granted data.
- `busy`  out  1  high in GRANT and GAP.

## Operation
- State register has three states: IDLE, GRANT, GAP.
- Registered round-robin pointer `ptr` (2 bits) names the highest-priority index.
- IDLE:
  - If `req` is nonzero, choose the first index i scanning ptr, ptr+1, ... (mod 4) with req[i]=1.
  - Load `gnt` = one-hot(i), `sel` = i, hold counter = 0, and go to GRANT.
  - If `req` is zero, stay in IDLE with `gnt` = 0.
- GRANT, with granted index g:
  - If req[g]=0 is sampled, go to GAP.
  - Otherwise, if hold counter == MAX_HOLD-1, go to GAP (forced release).
  - Otherwise, increment the hold counter and stay in GRANT.
  - Changes on `req` bits other than g are ignored during the tenure.
- On entry to GAP: `gnt` = 0, `ptr` = g+1 mod 4 (wraps 3 -> 0), and `sel` holds g.
- GAP always lasts exactly one cycle and then goes to IDLE. Arbitration therefore restarts from IDLE, so a forced-release requester that still requests has lowest priority next round.
- Output stage, every cycle: `out_data` <= the data_in pair indexed by `sel`, and `out_valid` <= |gnt.
- Hold counter is CNT_W bits wide, is never compared above MAX_HOLD-1, and cannot wrap.

## Timing
- Reset values, all at the first edge with rst=1:
  - state = IDLE, `ptr` = 0, hold counter = 0.
  - `gnt` = 0000, `sel` = 00, `out_data` = 00, `out_valid` = 0, `busy` = 0.
- `rst` overrides everything, including a tenure in progress. After reset, arbitration resumes from A-first priority.
- Request to grant: req sampled at edge t gives `gnt` high after edge t+1, because the edge at t leaves GAP/IDLE. From IDLE with a stable request, grant latency is 1 cycle.
- Grant to data: `out_data`/`out_valid` lag `gnt`/`sel` by exactly 1 cycle.
- Tenure length: grant lasts min(cycles until req[g] is sampled low, MAX_HOLD) cycles. `gnt` drops after the edge that samples req[g]=0.
- Gap between tenures: at least 1 idle `gnt` cycle (GAP) plus 1 arbitration cycle (IDLE). Back-to-back tenures are therefore spaced 2 cycles apart.
- Simultaneous requests are resolved by `ptr` only; no requester can be starved.
- `busy` is registered and matches state (GRANT or GAP).

## Test plan
- Reset mid-tenure:
  - Stimulus: grant B active, then rst=1 for 1 cycle.
  - Required: `gnt` = 0000, `sel` = 00, `out_valid` = 0 next cycle.
  - With req=1111 afterwards, the first grant is A (0001).
- Single requester:
  - Stimulus: req=0100, data_in C=10 held, MAX_HOLD=8.
  - Required: `gnt` = 0100 and `sel` = 10 one cycle later; `out_data` = 10 with `out_valid` = 1 one cycle after that.
  - Grant lasts exactly 8 cycles, then GAP, then IDLE, then re-grant to C.
- Round robin with all requesting:
  - Stimulus: req=1111, MAX_HOLD=2.
  - Required: grant order A, B, C, D, A, each tenure 2 cycles, 2-cycle spacing between tenures, `sel` 00, 01, 10, 11, 00.
- Early release:
  - Stimulus: A granted; drop req[0] on the 3rd grant cycle.
  - Required: `gnt` = 0000 on the next cycle and `ptr` = 1.
  - If req=1001 follows, the next grant is D (1000), not A.
- Pointer wrap:
  - Stimulus: D granted and released with req=0011.
  - Required: `ptr` wraps to 0 and the next grant is A.
- Data steering:
  - Stimulus: data_in=8'b11_10_01_00, each requester granted in turn.
  - Required: `out_data` = 00, 01, 10, 11 for A, B, C, D respectively, each appearing 1 cycle after the corresponding `sel`.
